imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 100 ++++++++++
 tb/tb_imem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory responder: program-load port, single-cycle-latency fetch port,
// and an IDLE/LOAD/RUN controller that gates which of the two is active.
module imem_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ip_load_en,
    input  logic [$clog2(DEPTH)-1:0] ip_load_addr,
    input  logic [31:0]              ip_load_data,
    input  logic                     ip_load_done,
    input  logic                     ip_fetch_en,
    input  logic [31:0]              ip_instr_addr_from_proc,
    output logic [31:0]              op_instr_from_imem,
    output logic                     op_instr_valid,
    output logic                     op_fetch_fault,
    output logic [1:0]               op_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_t;

    state_t        r_state;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_instr;
    logic          r_valid;
    logic          r_fault;

    logic          w_write;
    logic          w_misaligned;
    logic          w_out_of_range;
    logic          w_fault;
    logic [AW-1:0] w_word;

    // Writes depend on the registered state, so an asynchronous reset that
    // forces IDLE between edges also cancels a write that was about to land.
    assign w_write        = ip_load_en && (r_state == LOAD || r_state == RUN);
    assign w_misaligned   = |ip_instr_addr_from_proc[1:0];
    assign w_out_of_range = |ip_instr_addr_from_proc[31:AW+2];
    assign w_fault        = w_misaligned || w_out_of_range;
    assign w_word         = ip_instr_addr_from_proc[AW+1:2];

    // NOTE: the storage array has no reset; program contents must survive rst
    // and a reset branch here would also prevent mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[ip_load_addr] <= ip_load_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ip_load_en) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (ip_load_done) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // A load strobe takes priority and swallows a same-cycle fetch.
                    if (ip_load_en) begin
                        r_state <= LOAD;
                    end else if (ip_fetch_en) begin
                        r_valid <= 1'b1;
                        r_fault <= w_fault;
                        r_instr <= w_fault ? NOP_INSTR : r_mem[w_word];
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign op_instr_from_imem = r_instr;
    assign op_instr_valid     = r_valid;
    assign op_fetch_fault     = r_fault;
    assign op_state           = r_state;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: stimulus pushes expected fetch responses into
// a scoreboard queue; a negedge monitor pops and compares each valid response.
module tb_imem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        load_done;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic [1:0]  state;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   total;
    int   bad;

    imem_responder #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ip_load_en              (load_en),
        .ip_load_addr            (load_addr),
        .ip_load_data            (load_data),
        .ip_load_done            (load_done),
        .ip_fetch_en             (fetch_en),
        .ip_instr_addr_from_proc (fetch_addr),
        .op_instr_from_imem      (instr),
        .op_instr_valid          (valid),
        .op_fetch_fault          (fault),
        .op_state                (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid response must match the head of the scoreboard and
    // arrive exactly on its due cycle; a due entry with no valid is a miss.
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'h0, valid}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("fetch_data", instr, e.instr);
                check("fetch_fault", {31'h0, fault}, {31'h0, e.fault});
                check("fetch_latency", cyc, e.due);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            check("missing_valid", {31'h0, valid}, 32'h1);
            void'(sb.pop_front());
        end
    end

    task automatic load_cycle(input logic en, input logic [7:0] a, input logic [31:0] d,
                              input logic done);
        load_en   = en;
        load_addr = a;
        load_data = d;
        load_done = done;
        @(posedge clk);
        #1;
        load_en   = 1'b0;
        load_done = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_instr,
                         input logic exp_fault, input bit expect_resp);
        exp_t e;
        fetch_en   = 1'b1;
        fetch_addr = a;
        if (expect_resp) begin
            e.instr = exp_instr;
            e.fault = exp_fault;
            e.due   = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        fetch_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc        = 0;
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        load_en    = 1'b0;
        load_addr  = 8'h0;
        load_data  = 32'h0;
        load_done  = 1'b0;
        fetch_en   = 1'b0;
        fetch_addr = 32'h0;

        #12;
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_state", {30'h0, state}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fetches in IDLE are ignored; the monitor flags any valid.
        fetch(32'h0, 32'h0, 1'b0, 1'b0);
        fetch(32'h4, 32'h0, 1'b0, 1'b0);
        idle(1);
        check("idle_no_valid", {31'h0, valid}, 32'h0);
        check("idle_state", {30'h0, state}, 32'h0);

        // Enter LOAD and write the program plus the top word.
        load_cycle(1'b1, 8'd0, 32'h0050_0093, 1'b0);
        check("enter_load", {30'h0, state}, 32'h1);
        load_cycle(1'b1, 8'd0, 32'h0050_0093, 1'b0);
        load_cycle(1'b1, 8'd1, 32'h00A0_0113, 1'b0);
        load_cycle(1'b1, 8'd2, 32'h0020_81B3, 1'b0);
        load_cycle(1'b1, 8'd3, 32'h0000_0013, 1'b0);
        load_cycle(1'b1, 8'd255, 32'h1234_5678, 1'b0);
        load_cycle(1'b0, 8'd0, 32'h0, 1'b1);
        check("enter_run", {30'h0, state}, 32'h2);

        // Back-to-back fetches of the program.
        fetch(32'h0, 32'h0050_0093, 1'b0, 1'b1);
        fetch(32'h4, 32'h00A0_0113, 1'b0, 1'b1);
        fetch(32'h8, 32'h0020_81B3, 1'b0, 1'b1);
        fetch(32'hC, 32'h0000_0013, 1'b0, 1'b1);
        idle(2);

        // Misaligned fetch, fault held over an idle cycle, then cleared.
        fetch(32'h6, NOP, 1'b1, 1'b1);
        idle(1);
        check("fault_hold", {31'h0, fault}, 32'h1);
        check("instr_hold", instr, NOP);
        fetch(32'h0, 32'h0050_0093, 1'b0, 1'b1);
        idle(1);

        // Range boundaries: no wrap-around above 4*DEPTH, top word served.
        fetch(32'h400, NOP, 1'b1, 1'b1);
        fetch(32'h3FC, 32'h1234_5678, 1'b0, 1'b1);
        fetch(32'h1000, NOP, 1'b1, 1'b1);
        fetch(32'hFFFF_FFFC, NOP, 1'b1, 1'b1);
        fetch(32'h8, 32'h0020_81B3, 1'b0, 1'b1);
        idle(2);

        // Load strobe with a same-cycle fetch in RUN: fetch dropped, write kept.
        load_en   = 1'b1;
        load_addr = 8'd6;
        load_data = 32'hCAFE_F00D;
        fetch(32'h0, 32'h0, 1'b0, 1'b0);
        load_en = 1'b0;
        check("run_to_load", {30'h0, state}, 32'h1);
        idle(1);
        check("dropped_fetch", {31'h0, valid}, 32'h0);

        // Simultaneous write and load_done: write first, then RUN.
        load_cycle(1'b1, 8'd5, 32'hDEAD_BEEF, 1'b1);
        check("load_done_same", {30'h0, state}, 32'h2);
        fetch(32'h14, 32'hDEAD_BEEF, 1'b0, 1'b1);
        fetch(32'h18, 32'hCAFE_F00D, 1'b0, 1'b1);
        idle(2);

        // Asynchronous reset while a response is valid.
        fetch(32'h4, 32'h0, 1'b0, 1'b0);
        check("pre_rst_valid", {31'h0, valid}, 32'h1);
        check("pre_rst_data", instr, 32'h00A0_0113);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, valid}, 32'h0);
        check("async_rst_instr", instr, 32'h0);
        check("async_rst_fault", {31'h0, fault}, 32'h0);
        check("async_rst_state", {30'h0, state}, 32'h0);
        idle(1);
        rst = 1'b1;
        idle(1);

        // Reset asserted mid-LOAD cancels the pending write to word 0.
        load_cycle(1'b1, 8'd9, 32'h1111_1111, 1'b0);
        check("reload_entry", {30'h0, state}, 32'h1);
        load_en   = 1'b1;
        load_addr = 8'd0;
        load_data = 32'hBAD0_BAD0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        rst     = 1'b1;
        check("rst_in_load_state", {30'h0, state}, 32'h0);
        idle(1);

        // Re-enter, finish loading, and confirm contents survived reset.
        load_cycle(1'b1, 8'd9, 32'h1111_1111, 1'b0);
        load_cycle(1'b0, 8'd0, 32'h0, 1'b1);
        check("rerun_state", {30'h0, state}, 32'h2);
        fetch(32'h0, 32'h0050_0093, 1'b0, 1'b1);
        fetch(32'h3FC, 32'h1234_5678, 1'b0, 1'b1);
        idle(3);

        check("scoreboard_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
